regfile_2r1w: RTL
=================

# regfile_2r1w

Parametrised successor to the single-port 8x16 register file used by the RISC FSM datapath. Provides NREGS registers of WIDTH bits with two independent combinational read ports, one synchronous write port, optional write-to-read bypass, an optional hardwired-zero R0, and a sequenced clear engine that zeroes the array one register per cycle under a busy handshake. It sits between the controller FSM and the ALU/shifter operand paths.

## Interface
- WIDTH, 16, data width of each register
- NREGS, 8, number of registers (power of two, ≥2)
- AW, $clog2(NREGS), index width (derived; do not override)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  WIDTH  write data
- writenum  in  AW  write index
- write  in  1  write enable
- readnum_a  in  AW  read index, port A
- readnum_b  in  AW  read index, port B
- data_out_a  out  WIDTH  read data, port A (combinational)
- data_out_b  out  WIDTH  read data, port B (combinational)
- clear  in  1  request sequenced clear (single-cycle pulse or level)
- busy  out  1  clear engine active

## Operation
- Reset (rst_n=0, asynchronous): all registers 0, FSM IDLE, clear pointer 0, busy 0; data_out_a/b read 0.
- FSM states: IDLE, CLEAR.
- IDLE: write=1 commits data_in to reg[writenum] at the rising edge. clear=1 sampled at an edge moves to CLEAR with pointer 0.
- CLEAR: each edge writes 0 to reg[pointer], pointer increments; on the edge clearing index NREGS-1 return to IDLE, pointer 0.
- write while busy=1: dropped, no register changes except by the engine.
- clear while busy=1: ignored (no restart, no extension).
- write and clear in the same IDLE cycle: write commits at that edge, then the clear sequence wipes it.
- Read: data_out_x = reg[readnum_x]. Both ports may address the same index.
- Bypass (BYPASS=1, busy=0, write=1, writenum==readnum_x): data_out_x = data_in. No bypass while busy.
- ZERO_R0=1: index 0 reads 0 on both ports, bypass included; writes to index 0 dropped.
- No arithmetic beyond the pointer; pointer is AW bits and never wraps past NREGS-1.

## Timing
- Write latency: visible on read ports the cycle after the committing edge (same cycle with BYPASS=1).
- Read latency: zero (combinational from readnum_x and array).
- clear sampled at edge T: busy=1 from just after T through edge T+NREGS; busy=0 after edge T+NREGS. Exactly NREGS busy cycles.
- Registers with index < pointer read 0 during CLEAR; others retain old value until their edge.
- rst_n asserted mid-clear: immediate return to IDLE, busy 0, all registers 0; engine does not resume after release.
- rst_n deasserted: first functional edge is the first rising clk edge with rst_n=1.

## Structure
- Shared package regfile_pkg: FSM state enum (IDLE, CLEAR), default WIDTH/NREGS constants.
- One sub-module is natural: regfile_clear_seq (FSM + pointer, outputs busy, clear_we, clear_idx); top muxes engine write over external write.
- Array as a WIDTH x NREGS reg with per-entry async reset.

## Test plan
- Reset then read all indices on both ports -> 0; busy=0.
- Write 16'hA5A5 to R3, 16'h1234 to R7; read A=3, B=7 next cycle -> A5A5, 1234; same index on both ports -> identical data.
- BYPASS=1: write 16'hBEEF to R2 while readnum_a=2 -> data_out_a=BEEF same cycle; BYPASS=0 -> old value until next cycle.
- Fill all 8 with nonzero, pulse clear -> busy high exactly 8 cycles; R0..Rk read 0 progressively; writes during busy dropped; clear during busy ignored.
- Assert rst_n low at clear cycle 3 -> busy 0 immediately, all registers 0, no further engine activity after release.
- ZERO_R0=1, WIDTH=32, NREGS=16: write 32'hFFFFFFFF to R0 and R15 -> R0 reads 0 (incl. bypass), R15 reads FFFFFFFF; clear takes 16 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the 2-read/1-write register file and its clear engine.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear engine: walks a pointer over every register index, one per cycle, while busy is high.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  output logic          busy,
  output logic [AW-1:0] clear_idx,
  output clr_state_t    state
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  logic [AW-1:0] ptr;

  // Handshake: clear is sampled only in IDLE; while busy=1 the engine owns the
  // write port, external writes are dropped and further clear requests ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == LAST) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clear_idx = ptr;

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional same-cycle bypass, optional hardwired-zero R0 and a sequenced clear engine.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREGS   = DEF_NREGS,
  parameter int AW      = $clog2(NREGS),
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             clear,
  output logic             busy
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    clear_idx;
  clr_state_t       clr_state;
  logic             engine_we;
  logic             ext_we;

  regfile_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .busy      (busy),
    .clear_idx (clear_idx),
    .state     (clr_state)
  );

  assign engine_we = (clr_state == CLEAR);
  // The engine has priority; writes to a hardwired-zero R0 are simply discarded.
  assign ext_we    = write && !engine_we && !(ZERO_R0 != 0 && writenum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (engine_we) begin
      regs[clear_idx] <= '0;
    end else if (ext_we) begin
      regs[writenum] <= data_in;
    end
  end

  always_comb begin
    data_out_a = regs[readnum_a];
    if (BYPASS != 0 && !engine_we && write && writenum == readnum_a) data_out_a = data_in;
    if (ZERO_R0 != 0 && readnum_a == '0) data_out_a = '0;
  end

  always_comb begin
    data_out_b = regs[readnum_b];
    if (BYPASS != 0 && !engine_we && write && writenum == readnum_b) data_out_b = data_in;
    if (ZERO_R0 != 0 && readnum_b == '0) data_out_b = '0;
  end

endmodule
